// File: rtl/linebuffer_scanout_pkg.sv
// Shared line-buffer geometry, word/address types and the scan-out FSM state encoding.
package linebuffer_pkg;

   localparam int LB_WORD_W       = 128;
   localparam int LB_PIX_W        = 8;
   localparam int LB_PIX_PER_WORD = 16;
   localparam int LB_ADDR_W       = 7;

   typedef logic [LB_WORD_W-1:0] lb_word_t;
   typedef logic [LB_ADDR_W-1:0] lb_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      PRIME0,
      PRIME1,
      PRIME2,
      RUN,
      DONE
   } scanout_state_e;

endpackage

// File: rtl/linebuffer_scanout_shifter.sv
// Pixel shift register for one line-buffer word: scroll-aligned load, per-pixel shift-out,
// remaining-pixel count and the double-width (hscale) phase bit.
module lb_pixel_shifter
   import linebuffer_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  lb_word_t             load_word_i,
   input  logic [3:0]           load_skip_i,
   input  logic                 consume_i,
   input  logic                 hscale_i,
   output logic [LB_PIX_W-1:0]  pix_o,
   output logic                 empty_o,
   output logic                 will_empty_o
);

   lb_word_t   shift_q, shift_d;
   logic [4:0] remaining_q, remaining_d;
   logic       phase_q, phase_d;
   logic       advance;

   // With hscale set, the first emission of a pixel only flips the phase.
   assign advance      = consume_i && (!hscale_i || phase_q);
   assign pix_o        = shift_q[LB_PIX_W-1:0];
   assign empty_o      = (remaining_q == 5'd0);
   assign will_empty_o = advance && (remaining_q == 5'd1);

   always_comb begin
      shift_d     = shift_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      if (clear_i) begin
         remaining_d = 5'd0;
         phase_d     = 1'b0;
      end else begin
         if (consume_i) begin
            phase_d = hscale_i ? !phase_q : 1'b0;
         end
         if (advance) begin
            shift_d     = shift_q >> LB_PIX_W;
            remaining_d = remaining_q - 5'd1;
         end
         if (load_i) begin
            shift_d     = load_word_i >> {load_skip_i, 3'b000};
            remaining_d = 5'd16 - {1'b0, load_skip_i};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shift_q     <= '0;
         remaining_q <= 5'd0;
         phase_q     <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         remaining_q <= remaining_d;
         phase_q     <= phase_d;
      end
   end

endmodule

// File: rtl/linebuffer_scanout.sv
// Line-buffer scan-out: address sequencing, one-word prefetch and per-pixel serialisation.
// Optional LINEBUFFER_SCANOUT_HSCALE_EN adds an hscale input that doubles every pixel.
module linebuffer_scanout
   import linebuffer_pkg::*;
#(
   parameter int               LINE_WORDS    = 40,
   parameter logic [LB_PIX_W-1:0] BORDER_COLOUR = 8'h00
) (
   input  logic                 clk_pix,
   input  logic                 rst_pix_n,
   input  logic                 line_start,
   input  logic [3:0]           scroll_x,
   input  logic                 de,
`ifdef LINEBUFFER_SCANOUT_HSCALE_EN
   input  logic                 hscale,
`endif
   output lb_addr_t             addr_pix,
   input  lb_word_t             colour_pix,
   output logic [LB_PIX_W-1:0]  pix_colour,
   output logic                 pix_valid,
   output logic                 underrun,
   output scanout_state_e       dbg_state
);

   localparam logic [7:0] LW8 = 8'(LINE_WORDS);

   scanout_state_e      state_q, state_d;
   lb_addr_t            addr_q, addr_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [3:0]          scroll_q, scroll_d;
   lb_word_t            pf_q, pf_d;
   logic                pf_valid_q, pf_valid_d;
   logic                pend1_q, pend1_d;
   logic                pend2_q, pend2_d;
   logic [LB_PIX_W-1:0] pix_colour_q, pix_colour_d;
   logic                pix_valid_q, pix_valid_d;
   logic                underrun_q, underrun_d;

   logic                hscale_eff;
   logic                in_line, capture_now, exhausted, need_word;
   logic                from_pf, from_bus, consume;
   logic                sh_load, sh_empty, sh_will_empty;
   lb_word_t            sh_word;
   logic [3:0]          sh_skip;
   logic [LB_PIX_W-1:0] sh_pix;

`ifdef LINEBUFFER_SCANOUT_HSCALE_EN
   logic hscale_q;
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         hscale_q <= 1'b0;
      end else if (line_start) begin
         hscale_q <= hscale;
      end
   end
   assign hscale_eff = hscale_q;
`else
   assign hscale_eff = 1'b0;
`endif

   // A requested word sits on colour_pix two edges after addr_pix changes (pend1 -> pend2).
   assign in_line     = (state_q == PRIME2) || (state_q == RUN);
   assign capture_now = ((state_q == PRIME2) && (cnt_q > 8'd1)) || pend2_q;
   assign exhausted   = ((state_q == RUN) || (state_q == DONE)) && sh_empty && !pf_valid_q &&
                        !pend1_q && !pend2_q && (cnt_q == LW8);
   assign need_word   = in_line && (sh_empty || sh_will_empty);
   assign from_pf     = need_word && pf_valid_q;
   assign from_bus    = need_word && !pf_valid_q && capture_now;
   assign sh_load     = !line_start && ((state_q == PRIME1) || from_pf || from_bus);
   assign sh_word     = ((state_q == PRIME1) || !pf_valid_q) ? colour_pix : pf_q;
   assign sh_skip     = (state_q == PRIME1) ? scroll_q : 4'd0;
   assign consume     = de && !line_start && !sh_empty;

   lb_pixel_shifter u_shifter (
      .clk_i        (clk_pix),
      .rst_n_i      (rst_pix_n),
      .clear_i      (line_start),
      .load_i       (sh_load),
      .load_word_i  (sh_word),
      .load_skip_i  (sh_skip),
      .consume_i    (consume),
      .hscale_i     (hscale_eff),
      .pix_o        (sh_pix),
      .empty_o      (sh_empty),
      .will_empty_o (sh_will_empty)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      scroll_d     = scroll_q;
      pf_d         = pf_q;
      pf_valid_d   = pf_valid_q;
      pend1_d      = 1'b0;
      pend2_d      = pend1_q;
      pix_colour_d = pix_colour_q;
      pix_valid_d  = 1'b0;
      underrun_d   = underrun_q;

      case (state_q)
         IDLE:   state_d = IDLE;
         PRIME0: begin
            state_d = PRIME1;
            if (LINE_WORDS > 1) begin
               addr_d = lb_addr_t'(1);
               cnt_d  = 8'd2;
            end
         end
         PRIME1: state_d = PRIME2;
         PRIME2: state_d = RUN;
         RUN:    if (exhausted) state_d = DONE;
         DONE:   state_d = DONE;
         default: state_d = IDLE;
      endcase

      if (from_pf) pf_valid_d = 1'b0;
      if (capture_now && !from_bus) begin
         pf_d       = colour_pix;
         pf_valid_d = 1'b1;
      end
      // Every word taken into the shifter triggers the next fetch until the line is covered.
      if ((from_pf || from_bus) && (cnt_q < LW8)) begin
         addr_d  = cnt_q[LB_ADDR_W-1:0];
         cnt_d   = cnt_q + 8'd1;
         pend1_d = 1'b1;
      end

      if (de) begin
         pix_valid_d  = 1'b1;
         pix_colour_d = (sh_empty || line_start) ? BORDER_COLOUR : sh_pix;
         if (sh_empty && !exhausted && !line_start) underrun_d = 1'b1;
      end

      if (line_start) begin
         state_d    = PRIME0;
         addr_d     = '0;
         cnt_d      = 8'd1;
         scroll_d   = scroll_x;
         pf_valid_d = 1'b0;
         pend1_d    = 1'b0;
         pend2_d    = 1'b0;
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         cnt_q        <= 8'd0;
         scroll_q     <= 4'd0;
         pf_q         <= '0;
         pf_valid_q   <= 1'b0;
         pend1_q      <= 1'b0;
         pend2_q      <= 1'b0;
         pix_colour_q <= '0;
         pix_valid_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         scroll_q     <= scroll_d;
         pf_q         <= pf_d;
         pf_valid_q   <= pf_valid_d;
         pend1_q      <= pend1_d;
         pend2_q      <= pend2_d;
         pix_colour_q <= pix_colour_d;
         pix_valid_q  <= pix_valid_d;
         underrun_q   <= underrun_d;
      end
   end

   assign addr_pix   = addr_q;
   assign pix_colour = pix_colour_q;
   assign pix_valid  = pix_valid_q;
   assign underrun   = underrun_q;
   assign dbg_state  = state_q;

endmodule
